// File: rtl/imm_decode_stage.sv
// Decode stage: classifies the opcode into a one-hot EXTOp, builds the extended
// immediate and hands entries to execute through a 2-entry skid buffer.
module imm_decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_extop,
    output logic [31:0]     out_imm,
    output logic            out_illegal,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [5:0]      extop;
        logic [31:0]     imm;
        logic            illegal;
    } entry_t;

    state_t state, state_next;
    entry_t dec, m_q, s_q;
    logic   accept, xfer;
    logic   load_m, load_s, move_s;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.instr   = in_instr;
        dec.pc      = in_pc;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.extop = 6'b100000;
                    dec.imm   = {27'b0, in_instr[24:20]};
                end else begin
                    dec.extop = 6'b010000;
                    dec.imm   = imm_i;
                end
            end
            7'b0000011, 7'b1100111: begin
                dec.extop = 6'b010000;
                dec.imm   = imm_i;
            end
            7'b0100011: begin
                dec.extop = 6'b001000;
                dec.imm   = imm_s;
            end
            7'b1100011: begin
                dec.extop = 6'b000100;
                dec.imm   = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec.extop = 6'b000010;
                dec.imm   = imm_u;
            end
            7'b1101111: begin
                dec.extop = 6'b000001;
                dec.imm   = imm_j;
            end
            // R-type carries no immediate but is a legal opcode
            7'b0110011: dec.illegal = 1'b0;
            default:    dec.illegal = 1'b1;
        endcase
    end

    // Handshake: a beat moves when valid && ready are both high at the rising
    // edge; in_ready depends on registered state only, never on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        move_s     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_m     = 1'b1;
                        state_next = HALF;
                    end
                end
                HALF: begin
                    if (xfer && accept) begin
                        load_m = 1'b1;
                    end else if (xfer) begin
                        state_next = EMPTY;
                    end else if (accept) begin
                        load_s     = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        move_s     = 1'b1;
                        state_next = HALF;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m)      m_q <= dec;
            else if (move_s) m_q <= s_q;
            if (load_s)      s_q <= dec;
        end
    end

    assign out_instr   = m_q.instr;
    assign out_pc      = m_q.pc;
    assign out_extop   = m_q.extop;
    assign out_imm     = m_q.imm;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed vectors plus randomized traffic checked
// against a queue-based model of the stage and an arithmetic immediate model.
module tb_imm_decode_stage;

    localparam int PC_W = 32;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [5:0]      extop;
        logic [31:0]     imm;
        logic            illegal;
    } ent_t;
    localparam int EW = $bits(ent_t);

    logic            clk, rstn, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0]     in_instr, out_instr, out_imm;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [5:0]      out_extop;
    logic [1:0]      state_dbg;

    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic        dir_use = 1'b0;
    logic [5:0]  dir_extop;
    logic [31:0] dir_imm;
    logic        dir_ill;
    logic        last_acc;

    imm_decode_stage #(.PC_W(PC_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_extop(out_extop), .out_imm(out_imm), .out_illegal(out_illegal),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference decode, written as plain integer arithmetic on field values
    function automatic ent_t model(input logic [31:0] i, input logic [PC_W-1:0] pc);
        ent_t e;
        int   v;
        e.instr = i; e.pc = pc; e.extop = 6'd0; e.imm = 32'd0; e.illegal = 1'b0;
        v = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin
                if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) begin
                    e.extop = 6'b100000;
                    e.imm   = (i >> 20) & 32'd31;
                end else begin
                    e.extop = 6'b010000;
                    v = int'(i[31:20]);
                    if (i[31]) v = v - 4096;
                    e.imm = 32'(v);
                end
            end
            7'h23: begin
                e.extop = 6'b001000;
                v = int'({i[31:25], i[11:7]});
                if (i[31]) v = v - 4096;
                e.imm = 32'(v);
            end
            7'h63: begin
                e.extop = 6'b000100;
                v = int'({i[31], i[7], i[30:25], i[11:8]}) * 2;
                if (i[31]) v = v - 8192;
                e.imm = 32'(v);
            end
            7'h37, 7'h17: begin
                e.extop = 6'b000010;
                e.imm   = i & 32'hFFFFF000;
            end
            7'h6F: begin
                e.extop = 6'b000001;
                v = int'({i[31], i[19:12], i[20], i[30:21]}) * 2;
                if (i[31]) v = v - (1 << 21);
                e.imm = 32'(v);
            end
            7'h33:   e.illegal = 1'b0;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};
        logic [31:0] r;
        logic [6:0]  op;
        r  = $urandom;
        op = ops[$urandom_range(0, 10)];
        if (op == 7'h00) op = r[6:0];
        return {r[31:7], op};
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            h = ent_t'(exp_q[0]);
            check("out_instr",   out_instr,          h.instr);
            check("out_pc",      out_pc,             h.pc);
            check("out_extop",   32'(out_extop),     32'(h.extop));
            check("out_imm",     out_imm,            h.imm);
            check("out_illegal", 32'(out_illegal),   32'(h.illegal));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_instr",     out_instr,        32'd0);
        check("rst_pc",        out_pc,           32'd0);
        check("rst_extop",     32'(out_extop),   32'd0);
        check("rst_imm",       out_imm,          32'd0);
        check("rst_illegal",   32'(out_illegal), 32'd0);
    endtask

    // driver: check at mid-cycle, then advance one clock and update the model
    task automatic step();
        logic acc, xf;
        ent_t e;
        check_outputs();
        acc = rstn && in_valid && (exp_q.size() < 2);
        xf  = rstn && out_ready && (exp_q.size() > 0);
        e   = model(in_instr, in_pc);
        if (dir_use) begin
            e.extop = dir_extop; e.imm = dir_imm; e.illegal = dir_ill;
        end
        @(posedge clk);
        last_acc = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (xf) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(EW'(e));
                last_acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_accept(input string tag);
        int k;
        k = 0;
        last_acc = 1'b0;
        while (!last_acc && k < 20) begin
            step();
            k++;
        end
        if (!last_acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: observed no accept expected accept within 20 cycles", tag);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic use_dir,
                        input logic [5:0] extop, input logic [31:0] imm, input logic ill);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = $urandom;
        dir_use   = use_dir;
        dir_extop = extop;
        dir_imm   = imm;
        dir_ill   = ill;
        wait_accept("push_accept");
        in_valid = 1'b0;
        dir_use  = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; last_acc = 1'b0;
        dir_extop = '0; dir_imm = '0; dir_ill = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // I-type and shamt stream, one-cycle latency
        out_ready = 1'b1;
        push(32'hFFF00093, 1'b1, 6'b010000, 32'hFFFFFFFF, 1'b0);
        push(32'h00509093, 1'b1, 6'b100000, 32'h00000005, 1'b0);
        push(32'h4030D093, 1'b1, 6'b100000, 32'h00000003, 1'b0);
        repeat (3) step();

        // S/B/U/J stream
        push(32'h0020A423, 1'b1, 6'b001000, 32'h00000008, 1'b0);
        push(32'hFE000EE3, 1'b1, 6'b000100, 32'hFFFFFFFC, 1'b0);
        push(32'h123450B7, 1'b1, 6'b000010, 32'h12345000, 1'b0);
        push(32'hFF9FF06F, 1'b1, 6'b000001, 32'hFFFFFFF8, 1'b0);
        repeat (3) step();

        // back-pressure: two accepted, third waits for a free slot
        out_ready = 1'b0;
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        in_valid = 1'b1;
        in_instr = rand_instr();
        in_pc    = $urandom;
        repeat (3) step();
        out_ready = 1'b1;
        wait_accept("bp_third_accept");
        in_valid = 1'b0;
        repeat (4) step();

        // flush while full, with a new instruction offered in the same cycle
        out_ready = 1'b0;
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        flush    = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // R-type and unknown opcode
        push(32'h002081B3, 1'b1, 6'b000000, 32'h00000000, 1'b0);
        push(32'h0000007F, 1'b1, 6'b000000, 32'h00000000, 1'b1);
        repeat (3) step();

        // asynchronous reset between clock edges
        out_ready = 1'b0;
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        push(rand_instr(), 1'b0, '0, '0, 1'b0);
        repeat (3) step();

        // randomized traffic with occasional flushes
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
